// File: rtl/sync_ram_init_if.sv
// rtl/sync_ram_init_if.sv - access bus for the self-initialising synchronous RAM
interface sync_ram_init_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              clear;
    logic              cs;
    logic              we;
    logic              re;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] wmask;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              busy;

    modport master (
        output clear, cs, we, re, addr, wdata, wmask,
        input  rdata, rvalid, busy
    );

    modport slave (
        input  clear, cs, we, re, addr, wdata, wmask,
        output rdata, rvalid, busy
    );
endinterface

// File: rtl/sync_ram_init.sv
// rtl/sync_ram_init.sv - single-port RAM with bit-masked writes, registered read and fill sequencer
module sync_ram_init #(
    parameter int                 DATA_W   = 8,
    parameter int                 ADDR_W   = 8,
    parameter logic [DATA_W-1:0]  INIT_VAL = '0
) (
    input  logic          i_clk,
    input  logic          i_reset,
    sync_ram_init_if.slave s_bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W+1)'(DEPTH - 1);

    typedef enum logic {ST_INIT = 1'b0, ST_READY = 1'b1} state_t;

    state_t            r_state, w_state_nxt;
    logic [ADDR_W:0]   r_init_cnt, w_init_cnt_nxt;
    logic              r_busy, w_busy_nxt;
    logic [DATA_W-1:0] r_rdata;
    logic              r_rvalid;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic              w_rd_en;
    logic [DATA_W-1:0] w_rd_data;
    logic [DATA_W-1:0] w_old;
    logic [DATA_W-1:0] w_merged;

    assign w_old    = r_mem[s_bus.addr];
    assign w_merged = (w_old & ~s_bus.wmask) | (s_bus.wdata & s_bus.wmask);

    always_comb begin
        w_state_nxt    = r_state;
        w_init_cnt_nxt = r_init_cnt;
        w_busy_nxt     = r_busy;
        w_mem_we       = 1'b0;
        w_mem_addr     = s_bus.addr;
        w_mem_wdata    = w_merged;
        w_rd_en        = 1'b0;
        w_rd_data      = w_old;
        case (r_state)
            ST_INIT: begin
                w_mem_we       = 1'b1;
                w_mem_addr     = r_init_cnt[ADDR_W-1:0];
                w_mem_wdata    = INIT_VAL;
                w_init_cnt_nxt = r_init_cnt + CNT_ONE;
                if (r_init_cnt == CNT_LAST) begin
                    w_state_nxt = ST_READY;
                    w_busy_nxt  = 1'b0;
                end
            end
            ST_READY: begin
                // clear wins over any access presented in the same cycle
                if (s_bus.clear) begin
                    w_state_nxt    = ST_INIT;
                    w_init_cnt_nxt = '0;
                    w_busy_nxt     = 1'b1;
                end else if (s_bus.cs) begin
                    w_mem_we  = s_bus.we;
                    w_rd_en   = s_bus.re;
                    w_rd_data = s_bus.we ? w_merged : w_old;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= ST_INIT;
            r_init_cnt <= '0;
            r_busy     <= 1'b1;
            r_rdata    <= '0;
            r_rvalid   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_init_cnt <= w_init_cnt_nxt;
            r_busy     <= w_busy_nxt;
            r_rvalid   <= w_rd_en;
            if (w_rd_en) begin
                r_rdata <= w_rd_data;
            end
        end
    end

    // Array has no reset; the fill sequence establishes its contents.
    always_ff @(posedge i_clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    assign s_bus.rdata  = r_rdata;
    assign s_bus.rvalid = r_rvalid;
    assign s_bus.busy   = r_busy;
endmodule

// File: tb/tb_sync_ram_init.sv
// tb/tb_sync_ram_init.sv - directed self-checking bench for sync_ram_init
module tb_sync_ram_init;
    logic clk = 1'b0;
    logic reset0 = 1'b1;
    logic reset1 = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    sync_ram_init_if #(.DATA_W(8), .ADDR_W(8)) bus0 ();
    sync_ram_init_if #(.DATA_W(8), .ADDR_W(8)) bus1 ();

    sync_ram_init #(.DATA_W(8), .ADDR_W(8), .INIT_VAL(8'h00)) dut0 (
        .i_clk(clk), .i_reset(reset0), .s_bus(bus0.slave)
    );
    sync_ram_init #(.DATA_W(8), .ADDR_W(8), .INIT_VAL(8'hA5)) dut1 (
        .i_clk(clk), .i_reset(reset1), .s_bus(bus1.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle0();
        bus0.clear = 1'b0; bus0.cs = 1'b0; bus0.we = 1'b0; bus0.re = 1'b0;
        bus0.addr = '0; bus0.wdata = '0; bus0.wmask = '0;
    endtask

    task automatic wait_init(input string tag);
        int n = 0;
        while (bus0.busy === 1'b1 && n < 1000) begin
            tick();
            n++;
        end
        chk(tag, n, 256);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d, input logic [7:0] m);
        bus0.cs = 1'b1; bus0.we = 1'b1; bus0.re = 1'b0;
        bus0.addr = a; bus0.wdata = d; bus0.wmask = m;
        tick();
        idle0();
    endtask

    task automatic rd(input string tag, input logic [7:0] a, input logic [7:0] e);
        bus0.cs = 1'b1; bus0.we = 1'b0; bus0.re = 1'b1; bus0.addr = a;
        tick();
        chk({tag, "_rvalid"}, bus0.rvalid, 1);
        chk({tag, "_rdata"}, bus0.rdata, e);
        idle0();
    endtask

    function automatic logic [7:0] pat(input bit alt, input logic [7:0] c, input int a);
        if (alt) return (a % 2 == 0) ? 8'hAA : 8'h55;
        return c;
    endfunction

    task automatic write_all(input bit alt, input logic [7:0] c);
        for (int a = 0; a < 256; a++) begin
            bus0.cs = 1'b1; bus0.we = 1'b1; bus0.re = 1'b0;
            bus0.addr = 8'(a); bus0.wdata = pat(alt, c, a); bus0.wmask = 8'hFF;
            tick();
        end
        idle0();
    endtask

    // Back-to-back reads: one result per cycle, rvalid stays high.
    task automatic read_all(input string tag, input bit alt, input logic [7:0] c);
        for (int a = 0; a < 256; a++) begin
            bus0.cs = 1'b1; bus0.we = 1'b0; bus0.re = 1'b1; bus0.addr = 8'(a);
            tick();
            chk({tag, "_rvalid"}, bus0.rvalid, 1);
            chk({tag, "_rdata"}, bus0.rdata, pat(alt, c, a));
        end
        idle0();
    endtask

    initial begin
        idle0();
        bus1.clear = 1'b0; bus1.cs = 1'b0; bus1.we = 1'b0; bus1.re = 1'b0;
        bus1.addr = '0; bus1.wdata = '0; bus1.wmask = '0;

        // reset state and initial fill length
        tick();
        chk("rst_busy", bus0.busy, 1);
        chk("rst_rvalid", bus0.rvalid, 0);
        chk("rst_rdata", bus0.rdata, 8'h00);
        reset0 = 1'b0;
        wait_init("init_len");
        read_all("init_rd", 1'b0, 8'h00);

        // alternating pattern, two passes
        write_all(1'b1, 8'h00);
        read_all("alt1", 1'b1, 8'h00);
        write_all(1'b1, 8'h00);
        read_all("alt2", 1'b1, 8'h00);

        // masked write: F0 merged with 0F under mask 3C
        wr(8'h10, 8'hF0, 8'hFF);
        wr(8'h10, 8'h0F, 8'h3C);
        rd("mask", 8'h10, 8'hCC);

        // write-first on same-cycle write+read
        wr(8'h20, 8'h11, 8'hFF);
        bus0.cs = 1'b1; bus0.we = 1'b1; bus0.re = 1'b1;
        bus0.addr = 8'h20; bus0.wdata = 8'hEE; bus0.wmask = 8'hFF;
        tick();
        chk("wf_rvalid", bus0.rvalid, 1);
        chk("wf_rdata", bus0.rdata, 8'hEE);
        idle0();
        wr(8'h21, 8'h33, 8'hFF);
        chk("wr_only_rvalid", bus0.rvalid, 0);
        rd("raw", 8'h21, 8'h33);
        wr(8'h21, 8'hFF, 8'h00);
        rd("mask0", 8'h21, 8'h33);
        tick();
        chk("idle_rvalid", bus0.rvalid, 0);

        // clear with a read in the same cycle, writes ignored while busy
        write_all(1'b0, 8'h5A);
        rd("fill5a", 8'h05, 8'h5A);
        bus0.clear = 1'b1; bus0.cs = 1'b1; bus0.re = 1'b1; bus0.addr = 8'h06;
        tick();
        chk("clr_rvalid", bus0.rvalid, 0);
        chk("clr_busy", bus0.busy, 1);
        chk("clr_rdata_hold", bus0.rdata, 8'h5A);
        idle0();
        begin
            int n = 0;
            while (bus0.busy === 1'b1 && n < 1000) begin
                bus0.cs = 1'b1; bus0.we = 1'b1; bus0.re = 1'b1;
                bus0.addr = 8'h05; bus0.wdata = 8'h77; bus0.wmask = 8'hFF;
                bus0.clear = (n == 50);
                tick();
                chk("busy_rvalid", bus0.rvalid, 0);
                n++;
            end
            chk("clr_len", n, 256);
        end
        idle0();
        rd("clr_05", 8'h05, 8'h00);
        rd("clr_06", 8'h06, 8'h00);

        // reset in the middle of a fill
        reset0 = 1'b1;
        tick();
        reset0 = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        chk("mid_busy", bus0.busy, 1);
        reset0 = 1'b1;
        #1;
        chk("mid_rst_busy", bus0.busy, 1);
        reset0 = 1'b0;
        wait_init("mid_len");

        // reset during a read burst clears outputs asynchronously
        wr(8'h07, 8'h99, 8'hFF);
        bus0.cs = 1'b1; bus0.re = 1'b1; bus0.addr = 8'h07;
        tick();
        chk("burst_rdata", bus0.rdata, 8'h99);
        chk("burst_rvalid", bus0.rvalid, 1);
        reset0 = 1'b1;
        #1;
        chk("async_rdata", bus0.rdata, 8'h00);
        chk("async_rvalid", bus0.rvalid, 0);
        chk("async_busy", bus0.busy, 1);
        idle0();
        reset0 = 1'b0;
        wait_init("burst_len");
        rd("after_rst_07", 8'h07, 8'h00);

        // INIT_VAL = A5 instance
        tick();
        reset1 = 1'b0;
        begin
            int n = 0;
            while (bus1.busy === 1'b1 && n < 1000) begin
                tick();
                n++;
            end
            chk("a5_len", n, 256);
        end
        for (int a = 0; a < 256; a++) begin
            bus1.cs = 1'b1; bus1.re = 1'b1; bus1.addr = 8'(a);
            tick();
            chk("a5_rvalid", bus1.rvalid, 1);
            chk("a5_rdata", bus1.rdata, 8'hA5);
        end
        bus1.cs = 1'b0; bus1.re = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
